// File: rtl/vp_pkg.sv
// Shared constants for the multi-mode video processing stage: mode codes,
// luma weights and the pipeline depth that the sync/position delays must match.
package vp_pkg;

    localparam logic [2:0] MODE_PASS = 3'd0;
    localparam logic [2:0] MODE_GRAY = 3'd1;
    localparam logic [2:0] MODE_THR  = 3'd2;
    localparam logic [2:0] MODE_NEG  = 3'd3;
    localparam logic [2:0] MODE_BARS = 3'd4;

    // Fixed-point BT.601-style weights; they sum to 256 so white stays white.
    localparam int LUMA_R     = 77;
    localparam int LUMA_G     = 150;
    localparam int LUMA_B     = 29;
    localparam int LUMA_SHIFT = 8;

    localparam int PIPE_DEPTH = 3;

endpackage

// File: rtl/vp_delay.sv
// Reset-to-zero shift register used to keep side-band signals aligned with
// the pixel pipeline.
module vp_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vp_mode_pipe.sv
// Multi-mode pixel processing stage (pass/gray/threshold/negative/colour bars)
// with frame-boundary mode switching and sync/position outputs aligned to pixels.
module vp_mode_pipe
    import vp_pkg::*;
#(
    parameter int CH    = 3,
    parameter int DW    = 8,
    parameter int XW    = 11,
    parameter int YW    = 11,
    parameter int THR   = 128,
    parameter int BAR_W = 80
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             de_in,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    input  logic [CH*DW-1:0] pixel_in,
    input  logic [2:0]       sw,
    output logic             de_out,
    output logic             h_sync_out,
    output logic             v_sync_out,
    output logic [CH*DW-1:0] pixel_out,
    output logic [XW-1:0]    x_pos,
    output logic [YW-1:0]    y_pos,
    output logic [2:0]       mode_active
);

    localparam int PW  = 8 + DW;
    localparam int SW  = 10 + DW;
    localparam int PXW = CH * DW;
    localparam logic [DW:0]   THR_L = (DW+1)'(THR);
    localparam logic [XW-1:0] BAR_L = XW'(BAR_W);

    logic           r_dePrev;
    logic           r_vsPrev;
    logic [XW-1:0]  r_xCnt;
    logic [YW-1:0]  r_yCnt;
    logic [2:0]     r_modeActive;
    logic           w_deFall;
    logic           w_vsRise;

    logic           r1_de;
    logic [PXW-1:0] r1_pix;
    logic [2:0]     r1_mode;
    logic [XW-1:0]  r1_x;

    logic           r2_de;
    logic [PXW-1:0] r2_pix;
    logic [PXW-1:0] r2_neg;
    logic [2:0]     r2_mode;
    logic [2:0]     r2_bar;

    logic [PXW-1:0] r_pixelOut;
    logic [XW-1:0]  w_barQ;
    logic [2:0]     w_barIdx;
    logic [DW-1:0]  w_luma;
    logic [PXW-1:0] w_barPix;
    logic [2:0]     w_syncOut;
    logic [XW+YW-1:0] w_posOut;

    assign w_deFall = r_dePrev & ~de_in;
    assign w_vsRise = v_sync_in & ~r_vsPrev;

    // Position counters and the frame-boundary mode latch; a vsync rise wins
    // over a simultaneous line end so y always restarts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dePrev     <= 1'b0;
            r_vsPrev     <= 1'b0;
            r_xCnt       <= '0;
            r_yCnt       <= '0;
            r_modeActive <= MODE_PASS;
        end else begin
            r_dePrev <= de_in;
            r_vsPrev <= v_sync_in;
            if (w_deFall) begin
                r_xCnt <= '0;
            end else if (de_in && (r_xCnt != '1)) begin
                r_xCnt <= r_xCnt + 1'b1;
            end
            if (w_vsRise) begin
                r_yCnt <= '0;
            end else if (w_deFall && (r_yCnt != '1)) begin
                r_yCnt <= r_yCnt + 1'b1;
            end
            if (w_vsRise) begin
                r_modeActive <= sw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_de   <= 1'b0;
            r1_pix  <= '0;
            r1_mode <= MODE_PASS;
            r1_x    <= '0;
        end else begin
            r1_de   <= de_in;
            r1_pix  <= pixel_in;
            r1_mode <= r_modeActive;
            r1_x    <= r_xCnt;
        end
    end

    assign w_barQ   = r1_x / BAR_L;
    assign w_barIdx = (w_barQ > XW'(7)) ? 3'd7 : w_barQ[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_de   <= 1'b0;
            r2_pix  <= '0;
            r2_neg  <= '0;
            r2_mode <= MODE_PASS;
            r2_bar  <= 3'd0;
        end else begin
            r2_de   <= r1_de;
            r2_pix  <= r1_pix;
            r2_neg  <= ~r1_pix;
            r2_mode <= r1_mode;
            r2_bar  <= w_barIdx;
        end
    end

    generate
        if (CH == 3) begin : g_rgb
            logic [PW-1:0] r2_prodR;
            logic [PW-1:0] r2_prodG;
            logic [PW-1:0] r2_prodB;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r2_prodR <= '0;
                    r2_prodG <= '0;
                    r2_prodB <= '0;
                end else begin
                    r2_prodR <= PW'(LUMA_R) * PW'(r1_pix[2*DW +: DW]);
                    r2_prodG <= PW'(LUMA_G) * PW'(r1_pix[DW +: DW]);
                    r2_prodB <= PW'(LUMA_B) * PW'(r1_pix[0 +: DW]);
                end
            end

            assign w_luma   = DW'((SW'(r2_prodR) + SW'(r2_prodG) + SW'(r2_prodB)) >> LUMA_SHIFT);
            assign w_barPix = {{DW{r2_bar[2]}}, {DW{r2_bar[1]}}, {DW{r2_bar[0]}}};
        end else begin : g_mono
            assign w_luma   = r2_pix[DW-1:0];
            assign w_barPix = {CH{{DW{r2_bar[0]}}}};
        end
    endgenerate

    // Blanking forces black regardless of mode so downstream never sees junk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixelOut <= '0;
        end else if (!r2_de) begin
            r_pixelOut <= '0;
        end else begin
            case (r2_mode)
                MODE_PASS: r_pixelOut <= r2_pix;
                MODE_GRAY: r_pixelOut <= {CH{w_luma}};
                MODE_THR:  r_pixelOut <= ({1'b0, w_luma} >= THR_L) ? {PXW{1'b1}} : {PXW{1'b0}};
                MODE_NEG:  r_pixelOut <= r2_neg;
                MODE_BARS: r_pixelOut <= w_barPix;
                default:   r_pixelOut <= r2_pix;
            endcase
        end
    end

    vp_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_DEPTH)
    ) u_syncDelay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data ({de_in, h_sync_in, v_sync_in}),
        .o_data (w_syncOut)
    );

    vp_delay #(
        .WIDTH (XW + YW),
        .DEPTH (PIPE_DEPTH)
    ) u_posDelay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data ({r_xCnt, r_yCnt}),
        .o_data (w_posOut)
    );

    assign {de_out, h_sync_out, v_sync_out} = w_syncOut;
    assign {x_pos, y_pos} = w_posOut;
    assign pixel_out      = r_pixelOut;
    assign mode_active    = r_modeActive;

endmodule

// File: tb/tb_vp_mode_pipe.sv
// Directed bench for vp_mode_pipe: every mode, frame-boundary mode latch,
// colour-bar boundaries, position counters and mid-frame reset.
module tb_vp_mode_pipe;

    logic        clk;
    logic        rst_n;
    logic        de_in;
    logic        h_sync_in;
    logic        v_sync_in;
    logic [23:0] pixel_in;
    logic [2:0]  sw;
    logic        de_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic [23:0] pixel_out;
    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic [2:0]  mode_active;

    int vectors;
    int miscompares;

    int          barX   [8] = '{0, 79, 80, 159, 160, 320, 560, 639};
    logic [23:0] barExp [8] = '{24'h000000, 24'h000000, 24'h0000FF, 24'h0000FF,
                                24'h00FF00, 24'hFF0000, 24'hFFFFFF, 24'hFFFFFF};

    vp_mode_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .de_in       (de_in),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .pixel_in    (pixel_in),
        .sw          (sw),
        .de_out      (de_out),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .pixel_out   (pixel_out),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .mode_active (mode_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change just after a falling edge, so each call spans one rising edge.
    task automatic applyStimulus(input logic de, input logic hs, input logic vs, input logic [23:0] pix);
        de_in     = de;
        h_sync_in = hs;
        v_sync_in = vs;
        pixel_in  = pix;
        @(negedge clk);
    endtask

    task automatic vsyncPulse(input logic [2:0] swVal);
        sw = swVal;
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic sendPixel(input string tag, input logic [23:0] pix, input logic [23:0] expected);
        applyStimulus(1'b1, 1'b0, 1'b0, pix);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput(tag, 32'(pixel_out), 32'(expected));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        de_in       = 1'b0;
        h_sync_in   = 1'b0;
        v_sync_in   = 1'b0;
        pixel_in    = 24'h0;
        sw          = 3'd0;

        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pixel", 32'(pixel_out), 32'h0);
        checkOutput("rst_de", 32'(de_out), 32'h0);
        checkOutput("rst_mode", 32'(mode_active), 32'h0);
        checkOutput("rst_xpos", 32'(x_pos), 32'h0);
        checkOutput("rst_ypos", 32'(y_pos), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Passthrough and exact 3-cycle latency of pixel and syncs
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h123456);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("pass_early_pix", 32'(pixel_out), 32'h0);
        checkOutput("pass_early_de", 32'(de_out), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("pass_pix", 32'(pixel_out), 32'h123456);
        checkOutput("pass_de", 32'(de_out), 32'h1);
        checkOutput("pass_hs", 32'(h_sync_out), 32'h1);
        checkOutput("pass_xpos", 32'(x_pos), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("pass_de_end", 32'(de_out), 32'h0);
        checkOutput("pass_hs_end", 32'(h_sync_out), 32'h0);
        checkOutput("pass_blank", 32'(pixel_out), 32'h0);

        // Grayscale, with vsync delay checked on the way in
        sw = 3'd1;
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
        checkOutput("vs_early", 32'(v_sync_out), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("vs_delayed", 32'(v_sync_out), 32'h1);
        checkOutput("gray_mode", 32'(mode_active), 32'h1);
        sendPixel("gray_red", 24'hFF0000, 24'h4C4C4C);
        sendPixel("gray_white", 24'hFFFFFF, 24'hFFFFFF);
        sendPixel("gray_black", 24'h000000, 24'h000000);
        sendPixel("gray_green", 24'h00FF00, 24'h959595);

        // Threshold at and just below 128
        vsyncPulse(3'd2);
        sendPixel("thr_at", 24'h808080, 24'hFFFFFF);
        sendPixel("thr_below", 24'h7F7F7F, 24'h000000);

        vsyncPulse(3'd3);
        sendPixel("neg", 24'h0F00F0, 24'hF0FF0F);

        // Mid-frame switch must not take effect until the next vsync rise
        vsyncPulse(3'd0);
        checkOutput("latch_mode0", 32'(mode_active), 32'h0);
        sw = 3'd3;
        sendPixel("latch_hold", 24'h0F00F0, 24'h0F00F0);
        checkOutput("latch_mode_hold", 32'(mode_active), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 24'h0);
        checkOutput("latch_mode3", 32'(mode_active), 32'h3);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
        sendPixel("latch_neg", 24'h123456, 24'hEDCBA9);

        vsyncPulse(3'd6);
        sendPixel("mode6_pass", 24'hABCDEF, 24'hABCDEF);

        // Colour bars over a 640-pixel line, then line-end counter behaviour
        vsyncPulse(3'd4);
        for (int i = 0; i < 646; i++) begin
            int j;
            applyStimulus(i < 640, 1'b0, 1'b0, 24'h5A5A5A);
            j = i - 2;
            for (int k = 0; k < 8; k++) begin
                if (j == barX[k]) begin
                    checkOutput($sformatf("bar_pix_x%0d", j), 32'(pixel_out), 32'(barExp[k]));
                    checkOutput($sformatf("bar_xpos_x%0d", j), 32'(x_pos), 32'(j));
                    checkOutput($sformatf("bar_ypos_x%0d", j), 32'(y_pos), 32'h0);
                end
            end
            if (j == 640) begin
                checkOutput("bar_fall_pix", 32'(pixel_out), 32'h0);
                checkOutput("bar_fall_xpos", 32'(x_pos), 32'd640);
            end
            if (j == 641) begin
                checkOutput("bar_wrap_xpos", 32'(x_pos), 32'h0);
                checkOutput("bar_wrap_ypos", 32'(y_pos), 32'h1);
            end
        end

        // Reset in the middle of active negated video
        vsyncPulse(3'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h111111);
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h222222);
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h333333);
        checkOutput("prerst_pix", 32'(pixel_out), 32'hEEEEEE);
        checkOutput("prerst_mode", 32'(mode_active), 32'h3);
        #2;
        rst_n = 1'b0;
        de_in = 1'b0;
        #1;
        checkOutput("midrst_pix", 32'(pixel_out), 32'h0);
        checkOutput("midrst_de", 32'(de_out), 32'h0);
        checkOutput("midrst_mode", 32'(mode_active), 32'h0);
        checkOutput("midrst_xpos", 32'(x_pos), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h654321);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("postrst_early", 32'(pixel_out), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
        checkOutput("postrst_pix", 32'(pixel_out), 32'h654321);
        checkOutput("postrst_de", 32'(de_out), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
